// File: rtl/canon_pkg.sv
// Shared types and constants for the four-voice canon sequencer.
// Note divider table, score entry layout and per-voice state encoding.
package canon_pkg;

    typedef struct packed {
        logic [4:0] pitch;   // 0 = rest
        logic [2:0] dur;     // note length is dur+1 beats
    } score_entry_t;

    typedef enum logic [1:0] {
        V_WAIT,
        V_PEND,
        V_PLAY,
        V_DONE
    } voice_state_e;

    // Equal-tempered divider table; index 1 is about 73.4 Hz at 50 MHz.
    localparam logic [12:0] NOTE_DIV [0:31] = '{
        13'd0,    13'd5319, 13'd5020, 13'd4739, 13'd4473, 13'd4222, 13'd3985, 13'd3761,
        13'd3550, 13'd3351, 13'd3163, 13'd2985, 13'd2818, 13'd2660, 13'd2510, 13'd2370,
        13'd2237, 13'd2111, 13'd1993, 13'd1881, 13'd1775, 13'd1676, 13'd1582, 13'd1493,
        13'd1409, 13'd1330, 13'd1255, 13'd1185, 13'd1119, 13'd1056, 13'd997,  13'd941
    };

endpackage

// File: rtl/canon_score_rom.sv
// Combinational score lookup shared by all four voices.
// Holds up to 32 entries; SEQ_LEN sets the index width.
module canon_score_rom
    import canon_pkg::*;
#(
    parameter int SEQ_LEN = 32
) (
    input  logic [$clog2(SEQ_LEN)-1:0] idx_i,
    output score_entry_t               entry_o
);

    logic [4:0] idx5;
    logic [7:0] raw;

    assign idx5 = 5'(idx_i);

    always_comb begin
        raw = '0;
        unique case (idx5)
            5'd0:  raw = {5'd1,  3'd1};
            5'd1:  raw = {5'd0,  3'd0};
            5'd2:  raw = {5'd5,  3'd0};
            5'd3:  raw = {5'd8,  3'd2};
            5'd4:  raw = {5'd13, 3'd1};
            5'd5:  raw = {5'd0,  3'd1};
            5'd6:  raw = {5'd20, 3'd0};
            5'd7:  raw = {5'd31, 3'd3};
            5'd8:  raw = {5'd3,  3'd0};
            5'd9:  raw = {5'd10, 3'd1};
            5'd10: raw = {5'd0,  3'd0};
            5'd11: raw = {5'd17, 3'd2};
            5'd12: raw = {5'd25, 3'd0};
            5'd13: raw = {5'd12, 3'd1};
            5'd14: raw = {5'd6,  3'd0};
            5'd15: raw = {5'd0,  3'd2};
            5'd16: raw = {5'd2,  3'd1};
            5'd17: raw = {5'd9,  3'd0};
            5'd18: raw = {5'd14, 3'd3};
            5'd19: raw = {5'd0,  3'd0};
            5'd20: raw = {5'd22, 3'd1};
            5'd21: raw = {5'd28, 3'd0};
            5'd22: raw = {5'd4,  3'd2};
            5'd23: raw = {5'd11, 3'd0};
            5'd24: raw = {5'd0,  3'd1};
            5'd25: raw = {5'd16, 3'd0};
            5'd26: raw = {5'd19, 3'd1};
            5'd27: raw = {5'd7,  3'd0};
            5'd28: raw = {5'd26, 3'd2};
            5'd29: raw = {5'd0,  3'd0};
            5'd30: raw = {5'd30, 3'd0};
            5'd31: raw = {5'd1,  3'd7};
            default: raw = '0;
        endcase
    end

    assign entry_o = score_entry_t'(raw);

endmodule

// File: rtl/canon_sequencer.sv
// Four-voice canon score sequencer with beat tick and round-robin ROM slot scheduler.
// CANON_LOOP_EN: score pointer wraps and voices never finish (playback ends on stop only).
module canon_sequencer
    import canon_pkg::*;
#(
    parameter int SEQ_LEN = 32,
    parameter int BEAT_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [BEAT_W-1:0] beat_period,
    input  logic [3:0]        canon_delay,
    output logic [12:0]       divider1,
    output logic [10:0]       divider2,
    output logic [10:0]       divider3,
    output logic [10:0]       divider4,
    output logic [3:0]        gate,
    output logic              busy
);

    localparam int PTR_W = $clog2(SEQ_LEN);

    typedef enum logic {S_IDLE, S_RUN} top_state_e;

    top_state_e   state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [1:0]   slot_q, slot_d;
    logic [PTR_W-1:0] ptr_q [4], ptr_d [4];
    logic [5:0]   ent_q [4], ent_d [4];
    logic [3:0]   rem_q [4], rem_d [4];
    voice_state_e vs_q [4], vs_d [4];
    logic [3:0]   gate_q, gate_d;
    logic [12:0]  dv0_q, dv0_d;
    logic [10:0]  dv_q [1:3], dv_d [1:3];
`ifndef CANON_LOOP_EN
    logic [3:0]   last_q, last_d;
`endif

    logic [BEAT_W-1:0] period_m1;
    logic              tick;
    logic              all_done;
    logic [PTR_W-1:0]  rd_idx;
    score_entry_t      rd_entry;
    logic [12:0]       note;

    assign period_m1 = (beat_period == '0) ? '0 : beat_period - BEAT_W'(1);
    assign tick      = (state_q == S_RUN) && (beat_q == period_m1);
    assign rd_idx    = ptr_q[slot_q];
    assign note      = NOTE_DIV[rd_entry.pitch];

`ifdef CANON_LOOP_EN
    assign all_done = 1'b0;
`else
    assign all_done = (vs_q[0] == V_DONE) && (vs_q[1] == V_DONE) &&
                      (vs_q[2] == V_DONE) && (vs_q[3] == V_DONE);
`endif

    canon_score_rom #(.SEQ_LEN(SEQ_LEN)) u_rom (
        .idx_i   (rd_idx),
        .entry_o (rd_entry)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        slot_d  = slot_q;
        ptr_d   = ptr_q;
        ent_d   = ent_q;
        rem_d   = rem_q;
        vs_d    = vs_q;
        gate_d  = gate_q;
        dv0_d   = dv0_q;
        dv_d    = dv_q;
`ifndef CANON_LOOP_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_RUN;
                    beat_d  = '0;
                    slot_d  = '0;
                    for (int unsigned k = 0; k < 4; k++) begin
                        ptr_d[k] = '0;
                        rem_d[k] = '0;
                        ent_d[k] = 6'(k) * {2'b00, canon_delay};
                        vs_d[k]  = (k == 0 || canon_delay == 4'd0) ? V_PEND : V_WAIT;
                    end
`ifndef CANON_LOOP_EN
                    last_d = '0;
`endif
                end
            end
            S_RUN: begin
                if (stop || all_done) begin
                    state_d = S_IDLE;
                    gate_d  = '0;
                end else begin
                    beat_d = tick ? '0 : beat_q + BEAT_W'(1);
                    slot_d = slot_q + 2'd1;
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (tick && vs_q[k] == V_WAIT) begin
                            ent_d[k] = ent_q[k] - 6'd1;
                            if (ent_q[k] == 6'd1) vs_d[k] = V_PEND;
                        end
                        if (tick && vs_q[k] == V_PLAY) begin
                            rem_d[k] = rem_q[k] - 4'd1;
                            if (rem_q[k] == 4'd1) begin
`ifdef CANON_LOOP_EN
                                vs_d[k] = V_PEND;
`else
                                if (last_q[k]) begin
                                    vs_d[k]   = V_DONE;
                                    gate_d[k] = 1'b0;
                                end else begin
                                    vs_d[k] = V_PEND;
                                end
`endif
                            end
                        end
                    end
                    // A pending voice is only loaded in its own slot; ticks seen while pending are not counted.
                    if (vs_q[slot_q] == V_PEND) begin
                        vs_d[slot_q]  = V_PLAY;
                        rem_d[slot_q] = 4'(rd_entry.dur) + 4'd1;
                        if (rd_idx == PTR_W'(SEQ_LEN - 1)) begin
                            ptr_d[slot_q] = '0;
`ifndef CANON_LOOP_EN
                            last_d[slot_q] = 1'b1;
`endif
                        end else begin
                            ptr_d[slot_q] = rd_idx + PTR_W'(1);
                        end
                        gate_d[slot_q] = (rd_entry.pitch != '0);
                        if (rd_entry.pitch != '0) begin
                            if (slot_q == 2'd0) dv0_d = note;
                            else                dv_d[slot_q] = note[12:2];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            slot_q  <= '0;
            ptr_q   <= '{default: '0};
            ent_q   <= '{default: '0};
            rem_q   <= '{default: '0};
            vs_q    <= '{default: V_WAIT};
            gate_q  <= '0;
            dv0_q   <= '0;
            dv_q    <= '{default: '0};
`ifndef CANON_LOOP_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            slot_q  <= slot_d;
            ptr_q   <= ptr_d;
            ent_q   <= ent_d;
            rem_q   <= rem_d;
            vs_q    <= vs_d;
            gate_q  <= gate_d;
            dv0_q   <= dv0_d;
            dv_q    <= dv_d;
`ifndef CANON_LOOP_EN
            last_q  <= last_d;
`endif
        end
    end

    assign divider1 = dv0_q;
    assign divider2 = dv_q[1];
    assign divider3 = dv_q[2];
    assign divider4 = dv_q[3];
    assign gate     = gate_q;
    assign busy     = (state_q == S_RUN);

endmodule

// File: tb/tb_canon_sequencer.sv
// Bench for canon_sequencer: per-voice note schedule predicted from beat/slot arithmetic.
// Honours CANON_LOOP_EN the same way the design does.
module tb_canon_sequencer;
    import canon_pkg::*;

    localparam int SEQ_LEN = 8;
    localparam int BEAT_W  = 24;
    localparam int MAXC    = 4096;
    localparam int MAXL    = 512;
    localparam int BIG     = 1000000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [BEAT_W-1:0] beat_period = '0;
    logic [3:0]        canon_delay = '0;
    logic [12:0]       divider1;
    logic [10:0]       divider2, divider3, divider4;
    logic [3:0]        gate;
    logic              busy;

    canon_sequencer #(.SEQ_LEN(SEQ_LEN), .BEAT_W(BEAT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .beat_period (beat_period),
        .canon_delay (canon_delay),
        .divider1    (divider1),
        .divider2    (divider2),
        .divider3    (divider3),
        .divider4    (divider4),
        .gate        (gate),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int sp [32] = '{1,0,5,8,13,0,20,31,3,10,0,17,25,12,6,0,2,9,14,0,22,28,4,11,0,16,19,7,26,0,30,1};
    int sd [32] = '{1,0,0,2,1,1,0,3,0,1,0,2,0,1,0,2,1,0,3,0,1,0,2,0,1,0,1,0,2,0,0,7};

    int mdiv [4] = '{0, 0, 0, 0};
    int lcy [4][MAXL];
    int lpt [4][MAXL];
    int nld [4];
    int done_c [4];
    int end_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the first RUN cycle; a tick occurs in cycle t when (t+1) is a multiple of the period.
    task automatic build(input int bp, input int d, input int cs);
        int p, ready, ptr, lc, nt, te, maxdone;
        p = (bp == 0) ? 1 : bp;
        maxdone = 0;
        for (int k = 0; k < 4; k++) begin
            nld[k] = 0;
            done_c[k] = BIG;
            ptr = 0;
            ready = (k * d == 0) ? 0 : k * d * p;
            while (1) begin
                lc = ready;
                while (lc % 4 != k) lc++;
                if (lc >= cs || lc >= MAXC || nld[k] >= MAXL) break;
                lcy[k][nld[k]] = lc;
                lpt[k][nld[k]] = ptr;
                nld[k]++;
                nt = (lc + 1) / p + sd[ptr] + 1;
                te = nt * p - 1;
                ptr++;
                if (ptr == SEQ_LEN) begin
`ifdef CANON_LOOP_EN
                    ptr = 0;
`else
                    done_c[k] = te + 1;
                    break;
`endif
                end
                ready = te + 1;
            end
            if (done_c[k] > maxdone) maxdone = done_c[k];
        end
        end_c = (cs + 1 < maxdone + 1) ? cs + 1 : maxdone + 1;
    endtask

    task automatic do_run(input int bp, input int d, input int cs_in, input int sb);
        int cs;
        int idx [4];
        int g [4];
        int pv;
        logic [3:0] eg;
        cs = cs_in;
`ifdef CANON_LOOP_EN
        if (cs >= BIG) cs = 300;
`endif
        build(bp, d, cs);
        if (end_c + 3 > MAXC) begin
            $display("FAIL model_horizon: observed=%0d required<=%0d", end_c + 3, MAXC);
            $fatal(1, "run too long");
        end
        for (int k = 0; k < 4; k++) begin
            idx[k] = 0;
            g[k] = 0;
        end
        @(negedge clk);
        beat_period = BEAT_W'(bp);
        canon_delay = 4'(d);
        start = 1'b1;
        for (int c = 0; c < end_c + 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            eg = '0;
            for (int k = 0; k < 4; k++) begin
                while (idx[k] < nld[k] && lcy[k][idx[k]] < c) begin
                    pv = sp[lpt[k][idx[k]]];
                    if (pv != 0) begin
                        mdiv[k] = (k == 0) ? int'(NOTE_DIV[pv]) : int'(NOTE_DIV[pv]) / 4;
                        g[k] = 1;
                    end else begin
                        g[k] = 0;
                    end
                    idx[k]++;
                end
                if (c < end_c && c < done_c[k] && g[k] == 1) eg[k] = 1'b1;
            end
            check($sformatf("gate bp=%0d d=%0d c=%0d", bp, d, c), 32'(gate), 32'(eg));
            check($sformatf("busy bp=%0d d=%0d c=%0d", bp, d, c), 32'(busy), (c < end_c) ? 32'd1 : 32'd0);
            check($sformatf("div1 c=%0d", c), 32'(divider1), mdiv[0]);
            check($sformatf("div2 c=%0d", c), 32'(divider2), mdiv[1]);
            check($sformatf("div3 c=%0d", c), 32'(divider3), mdiv[2]);
            check($sformatf("div4 c=%0d", c), 32'(divider4), mdiv[3]);
            if (c == cs) stop = 1'b1;
            if (c == sb && sb < end_c) start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_div1", 32'(divider1), 0);
        check("reset_div2", 32'(divider2), 0);
        check("reset_gate", 32'(gate), 0);
        check("reset_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        do_run(10, 0, BIG, -1);
        do_run(8, 2, BIG, 5);
        do_run(0, 1, BIG, -1);
        do_run(1, 0, BIG, 2);
        do_run(6, 1, 40, 3);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        beat_period = BEAT_W'(3);
        canon_delay = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async_div1", 32'(divider1), 0);
        check("async_div4", 32'(divider4), 0);
        check("async_gate", 32'(gate), 0);
        check("async_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) mdiv[k] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_busy%0d", i), 32'(busy), 0);
            check($sformatf("post_reset_gate%0d", i), 32'(gate), 0);
        end

        do_run(2, 0, BIG, -1);

        // start and stop together from IDLE: stop wins
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("startstop_busy%0d", i), 32'(busy), 0);
            check($sformatf("startstop_gate%0d", i), 32'(gate), 0);
            check($sformatf("startstop_div1_%0d", i), 32'(divider1), mdiv[0]);
            @(negedge clk);
        end

        for (int r = 0; r < 6; r++) begin
            int bp, d, cs, sb;
            bp = int'($urandom_range(0, 7));
            d  = int'($urandom_range(0, 15));
            cs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 200)) : BIG;
            sb = int'($urandom_range(1, 30));
            do_run(bp, d, cs, sb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
